tcp_notify_router: RTL and testbench

Routes TCP receive notifications from the offload engine to the owning vFPGA region. Sits directly downstream of the TCP port table. For each notification it:
- drives the table's lookup address from the destination port;
- waits for the registered read;
- decodes the returned session word into vfid, pid and dest;
- forwards the notification on the matching per-region interface, or drops it if no listener owns the port.

---
 rtl/tcp_notify_router_if.sv | 11 +
 rtl/tcp_notify_router.sv | 138 +++++++++++++
 tb/tb_tcp_notify_router.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_notify_router_if.sv
// Valid/ready notification channel; data packs the notification fields with dst_port in the LSBs.
interface tcp_notify_router_if #(
    parameter int DW = 80
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/tcp_notify_router.sv
// Routes TCP receive notifications to the owning vFPGA region via a port-table lookup.
// Optional drop counter enabled by defining TCP_NOTIFY_DROP_CNT_EN.
module tcp_notify_router #(
    parameter int N_REGIONS      = 1,
    parameter int LUP_LAT        = 2,
    parameter int DROP_CNT_BITS  = 32,
    parameter int TCP_PORT_OFFS  = 4096,
    parameter int TCP_PORT_ORDER = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    tcp_notify_router_if.s            s_notify,
    tcp_notify_router_if.m            m_notify [N_REGIONS],
    output logic [TCP_PORT_ORDER-1:0] port_addr,
    input  logic [15:0]               rsid_in,
    output logic [DROP_CNT_BITS-1:0]  drop_cnt
);
    // Session word: {valid, vfid[3:0], pid[5:0], dest[4:0]}
    localparam int VFID_BITS = 4;
    localparam int PID_BITS  = 6;
    localparam int DEST_BITS = 5;
    localparam int IN_W      = 80;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LUP, ST_WAIT, ST_CHECK, ST_SEND, ST_DROP
    } state_t;

    state_t                    state_q;
    logic                      ready_q;
    logic [N_REGIONS-1:0]      valid_q;
    logic [IN_W-1:0]           data_q;
    logic [PID_BITS-1:0]       pid_q;
    logic [DEST_BITS-1:0]      dest_q;
    logic [TCP_PORT_ORDER-1:0] port_addr_q;
    logic [1:0]                cnt_q;

    logic [16:0]               off_d;
    logic                      off_oor_d;
    logic [N_REGIONS-1:0]      rdy_vec;
    logic                      rs_valid;
    logic [VFID_BITS-1:0]      rs_vfid;
    logic [PID_BITS-1:0]       rs_pid;
    logic [DEST_BITS-1:0]      rs_dest;

    // Negative offsets show up in bit 16 of the 17-bit difference.
    assign off_d     = {1'b0, s_notify.data[15:0]} - 17'(TCP_PORT_OFFS);
    assign off_oor_d = off_d[16] | (|off_d[15:TCP_PORT_ORDER]);

    assign rs_valid = rsid_in[15];
    assign rs_vfid  = rsid_in[14:11];
    assign rs_pid   = rsid_in[10:5];
    assign rs_dest  = rsid_in[4:0];

    assign s_notify.ready = ready_q;
    assign port_addr      = port_addr_q;

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_out
        assign m_notify[g].valid = valid_q[g];
        assign m_notify[g].data  = {pid_q, dest_q, data_q};
        assign rdy_vec[g]        = m_notify[g].ready;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            valid_q     <= '0;
            data_q      <= '0;
            pid_q       <= '0;
            dest_q      <= '0;
            port_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && s_notify.valid) begin
                        ready_q <= 1'b0;
                        data_q  <= s_notify.data;
                        if (off_oor_d) begin
                            state_q <= ST_DROP;
                        end else begin
                            port_addr_q <= off_d[TCP_PORT_ORDER-1:0];
                            state_q     <= ST_LUP;
                        end
                    end
                end
                ST_LUP: begin
                    cnt_q   <= 2'(LUP_LAT - 1);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 2'd0) state_q <= ST_CHECK;
                    else               cnt_q   <= cnt_q - 2'd1;
                end
                ST_CHECK: begin
                    if (!rs_valid || ({1'b0, rs_vfid} >= 5'(N_REGIONS))) begin
                        state_q <= ST_DROP;
                    end else begin
                        pid_q  <= rs_pid;
                        dest_q <= rs_dest;
                        for (int i = 0; i < N_REGIONS; i++)
                            valid_q[i] <= (rs_vfid == VFID_BITS'(i));
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (|(valid_q & rdy_vec)) begin
                        valid_q <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TCP_NOTIFY_DROP_CNT_EN
    logic [DROP_CNT_BITS-1:0] drop_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset)
            drop_cnt_q <= '0;
        else if (state_q == ST_DROP && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tcp_notify_router.sv
// Bench for tcp_notify_router: transaction-timing model plus directed literal checks.
module tb_tcp_notify_router;
    localparam int L      = 2;
    localparam int NR     = 2;
    localparam int OFFS   = 4096;
    localparam int ORD    = 8;
    localparam int DW_IN  = 80;
    localparam int DW_OUT = 91;
`ifdef TCP_NOTIFY_DROP_CNT_EN
    localparam int DEN = 1;
`else
    localparam int DEN = 0;
`endif

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    tcp_notify_router_if #(.DW(DW_IN))  s_if ();
    tcp_notify_router_if #(.DW(DW_OUT)) m_if [NR] ();

    logic [ORD-1:0] port_addr;
    logic [15:0]    rsid_in;
    logic [31:0]    drop_cnt;

    tcp_notify_router #(
        .N_REGIONS(NR), .LUP_LAT(L), .DROP_CNT_BITS(32),
        .TCP_PORT_OFFS(OFFS), .TCP_PORT_ORDER(ORD)
    ) dut (
        .aclk(clk), .areset(areset), .s_notify(s_if), .m_notify(m_if),
        .port_addr(port_addr), .rsid_in(rsid_in), .drop_cnt(drop_cnt)
    );

    // Port table with an L-cycle registered read
    logic [15:0] ptab [256];
    logic [15:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= ptab[port_addr];
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign rsid_in = pipe[L-1];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: outcome and timing of each notification derived from the accept edge
    bit              exp_ready = 1'b0;
    bit [NR-1:0]     exp_valid = '0;
    logic [90:0]     exp_data = '0;
    logic [ORD-1:0]  exp_pa = '0;
    logic [31:0]     exp_drop = '0;
    bit              busy = 1'b0;
    bit              drop_pend = 1'b0;
    int              t_valid = -1;
    int              t_idle = -1;
    int              vreg = 0;
    logic [90:0]     pend_data = '0;

    always @(posedge clk) begin
        bit rdy_pre;
        int dst;
        logic [15:0] ent;
        rdy_pre = exp_ready;
        cyc++;
        if (areset) begin
            exp_ready = 1'b0; exp_valid = '0; exp_pa = '0; exp_drop = '0;
            busy = 1'b0; drop_pend = 1'b0; t_valid = -1; t_idle = -1;
        end else begin
            if (!busy && !exp_ready) exp_ready = 1'b1;
            if (rdy_pre && s_if.valid) begin
                busy = 1'b1;
                exp_ready = 1'b0;
                dst = int'(s_if.data[15:0]);
                if (dst < OFFS || dst >= OFFS + 256) begin
                    t_idle = cyc + 1;
                    drop_pend = 1'b1;
                end else begin
                    exp_pa = ORD'(dst - OFFS);
                    ent = ptab[exp_pa];
                    if (!ent[15] || int'(ent[14:11]) >= NR) begin
                        t_idle = cyc + L + 3;
                        drop_pend = 1'b1;
                    end else begin
                        vreg = int'(ent[14:11]);
                        t_valid = cyc + L + 2;
                        pend_data = {ent[10:5], ent[4:0], s_if.data};
                    end
                end
            end
            if ((exp_valid[0] && m_if[0].ready) || (exp_valid[1] && m_if[1].ready)) begin
                exp_valid = '0;
                exp_ready = 1'b1;
                busy = 1'b0;
            end
            if (cyc == t_valid) begin
                exp_valid = NR'(1 << vreg);
                exp_data = pend_data;
            end
            if (cyc == t_idle) begin
                exp_ready = 1'b1;
                busy = 1'b0;
                if (drop_pend && DEN == 1) exp_drop = exp_drop + 1;
                drop_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("s_ready", s_if.ready, exp_ready);
            chk("valid0", m_if[0].valid, exp_valid[0]);
            chk("valid1", m_if[1].valid, exp_valid[1]);
            if (exp_valid != 0)
                chk("m_data", exp_valid[0] ? m_if[0].data : m_if[1].data, exp_data);
            chk("port_addr", port_addr, exp_pa);
            chk("drop_cnt", drop_cnt, exp_drop);
        end
    end

    task automatic send(input logic [15:0] sid, input logic [15:0] dst);
        @(negedge clk);
        s_if.valid = 1'b1;
        s_if.data  = {sid, sid + 16'd1, 32'hC0A8_0000 | {16'h0, sid}, dst};
        for (int k = 0; k < 100 && !s_if.ready; k++) @(negedge clk);
        if (!s_if.ready) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int k = 0; k < 100 && !s_if.ready; k++) @(negedge clk);
        if (!s_if.ready) chk("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ptab[i] = 16'h0;
        ptab[5]  = {1'b1, 4'd1, 6'd3, 5'd2};
        ptab[7]  = {1'b0, 4'd1, 6'd3, 5'd2};
        ptab[9]  = {1'b1, 4'd3, 6'd1, 5'd1};
        ptab[12] = {1'b1, 4'd0, 6'd10, 5'd7};
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if[0].ready = 1'b1;
        m_if[1].ready = 1'b1;

        areset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", s_if.ready, 1'b0);
        chk("rst_valid0", m_if[0].valid, 1'b0);
        chk("rst_port_addr", port_addr, 8'h00);
        chk("rst_drop", drop_cnt, 32'd0);
        areset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_if.ready, 1'b1);

        // Routed to region 1
        send(16'h0012, 16'h1005);
        repeat (L + 1) @(posedge clk);
        @(negedge clk);
        chk("t1_early", m_if[1].valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_valid", m_if[1].valid, 1'b1);
        chk("t1_sid", m_if[1].data[79:64], 16'h0012);
        chk("t1_pid", m_if[1].data[90:85], 6'd3);
        chk("t1_dest", m_if[1].data[84:80], 5'd2);
        chk("t1_valid0", m_if[0].valid, 1'b0);
        wait_idle();

        // Listener bit clear
        send(16'h0021, 16'h1007);
        wait_idle();
        chk("t2_drop", drop_cnt, 32'(1 * DEN));
        chk("t2_port_addr", port_addr, 8'h07);

        // Out-of-range ports, both sides
        send(16'h0022, 16'h0FFF);
        @(negedge clk);
        chk("t3a_busy", s_if.ready, 1'b0);
        @(negedge clk);
        chk("t3a_ready", s_if.ready, 1'b1);
        send(16'h0023, 16'h1100);
        @(negedge clk);
        chk("t3b_busy", s_if.ready, 1'b0);
        @(negedge clk);
        chk("t3b_ready", s_if.ready, 1'b1);
        chk("t3_port_addr", port_addr, 8'h07);
        chk("t3_drop", drop_cnt, 32'(3 * DEN));

        // vfid beyond the region count
        send(16'h0024, 16'h1009);
        wait_idle();
        chk("t4_drop", drop_cnt, 32'(4 * DEN));

        // Backpressure on region 0
        @(negedge clk);
        m_if[0].ready = 1'b0;
        send(16'h0025, 16'h100C);
        for (int k = 0; k < 20 && !m_if[0].valid; k++) @(negedge clk);
        chk("t5_valid", m_if[0].valid, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", m_if[0].valid, 1'b1);
            chk("t5_hold_data", m_if[0].data,
                {6'd10, 5'd7, 16'h0025, 16'h0026, 32'hC0A8_0025, 16'h100C});
            chk("t5_hold_sready", s_if.ready, 1'b0);
        end
        m_if[0].ready = 1'b1;
        wait_idle();
        send(16'h0030, 16'h1005);
        for (int k = 0; k < 20 && !m_if[1].valid; k++) @(negedge clk);
        chk("t5_next", m_if[1].data[79:64], 16'h0030);
        wait_idle();

        // Reset while waiting on the table
        send(16'h0027, 16'h1005);
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        chk("t6_ready_rel", s_if.ready, 1'b0);
        @(negedge clk);
        chk("t6_ready", s_if.ready, 1'b1);
        chk("t6_drop", drop_cnt, 32'd0);
        for (int k = 0; k < L + 6; k++) begin
            @(negedge clk);
            chk("t6_no_out", m_if[1].valid, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
